ws_block_writer: RTL and testbench
==================================

WS_BLOCK_WRITER -- requirements
Module: ws_block_writer

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- IMG_WIDTH, 320, luma width in pixels; multiple of 16.
- IMG_HEIGHT, 240, luma height in pixels; multiple of 8.
- CHROMA_HDIV, 2, chroma horizontal decimation (1 or 2).
- CHROMA_VDIV, 1, chroma vertical decimation (1 or 2).
- NUM_PLANES, 3, planes written per frame (1 = Y only, 3 = Y,U,V).
- Y_BASE, 0, luma SRAM word base.
- U_BASE, 38400, U plane SRAM word base.
- V_BASE, 57600, V plane SRAM word base.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- CLOCK_50_I, in, 1, clock; Resetn, in, 1, reset.
- WS_start, in, 1, start one 8x8 block write.
- WS_bank, in, 1, DPRAM half holding the block; sampled with WS_start.
- WS_frame_restart, in, 1, zero block position; honoured only in IDLE.
- WS_busy, out, 1, high from accepted start to WS_done inclusive.
- WS_done, out, 1, one-cycle pulse per completed block.
- WS_frame_done, out, 1, one-cycle pulse coincident with WS_done of the last block of the last plane.
- s_read_address, out, 7, DPRAM word address {bank,1'b0,word[4:0]}.
- s_read_data, in, 32, [31:16] even pixel, [15:0] odd pixel, signed 16-bit; valid one cycle after address.
- s_write_enable, out, 1, tied 0.
- SRAM_address, out, 18, SRAM word address.
- SRAM_write_data, out, 16, {even pixel, odd pixel} clipped to 8 bits each.
- SRAM_we_n, out, 1, active-low SRAM write enable.

REQ-003 Reset SHALL be Resetn, asynchronous, active-low; the clock SHALL be CLOCK_50_I.

Function
REQ-004 The FSM SHALL have states IDLE, FETCH, WRITE, DONE.
REQ-005 In IDLE, WS_start=1 SHALL latch WS_bank, set WS_busy, and go to FETCH, with s_read_address = word 0.
REQ-006 FETCH SHALL last one cycle, issue word 1, and go to WRITE.
REQ-007 WRITE SHALL last 32 cycles. In each cycle k (0..31) the block SHALL register SRAM_address, SRAM_write_data and SRAM_we_n=0 from word k, and issue a read of word k+1 while k<31.
REQ-008 SRAM_we_n SHALL be low for exactly 32 consecutive cycles per block. The first low cycle SHALL begin 2 edges after the edge sampling WS_start.
REQ-009 DONE SHALL drive SRAM_we_n=1, pulse WS_done (and WS_frame_done if applicable), advance the block position, and return to IDLE. WS_busy SHALL drop the cycle after DONE.
REQ-010 Word k SHALL map to row r=k[4:2] and word column c=k[1:0].
REQ-011 The SRAM address SHALL be base + (RB*8+r)*WPR + CB*4 + c.
REQ-012 WPR (words per row) SHALL be IMG_WIDTH/2 for Y and IMG_WIDTH/(2*CHROMA_HDIV) for U/V. Multiplications SHALL be shift-add or constant; the result SHALL be 18 bits, unsigned.
REQ-013 Each pixel SHALL be clipped as a signed 16-bit value: <0 -> 0, >255 -> 255, otherwise its low 8 bits.
REQ-014 Block position SHALL advance as follows:
- CB increments after each block.
- At CB = plane_width/8-1, CB wraps to 0 and RB increments.
- At RB = plane_height/8-1, RB wraps to 0 and the plane advances Y -> U -> V.
- After the last plane (plane index NUM_PLANES-1), the position returns to Y,0,0 and WS_frame_done pulses.
REQ-015 WS_start SHALL be ignored outside IDLE.
REQ-016 WS_frame_restart in IDLE SHALL zero CB, RB and plane. If WS_frame_restart and WS_start are both high in IDLE, the restart SHALL apply first, and that block SHALL be written at Y,0,0.
REQ-017 s_read_address SHALL be {bank,1'b0,00000} in IDLE and DONE.

Reset
REQ-018 While Resetn=0, the block SHALL hold these values:
- state = IDLE; CB, RB and plane = 0; latched bank = 0.
- SRAM_we_n = 1; SRAM_address = 0; SRAM_write_data = 0.
- WS_done, WS_frame_done and WS_busy = 0.
REQ-019 Reset asserted mid-WRITE SHALL abort immediately, with SRAM_we_n=1 asynchronously. The next start SHALL write block Y,0,0.

Verification
REQ-020 The bench SHALL cover these directed scenarios (defaults unless noted):
- First block, bank 0, DPRAM word k = {16'(2k),16'(2k+1)} -> 32 writes at addresses 0-3, 160-163, ..., 1120-1123; data {2k,2k+1}. we_n low 32 cycles starting 2 edges after start. WS_done pulses once.
- Clipping: words {16'hFFF6,16'd300} and {16'd128,16'h8000} -> data 16'h00FF and 16'h8000.
- Position wrap: 40th Y block -> base 0+4*39=156. 41st block -> base 8*160=1280. Block 1201 -> U_BASE 38400.
- Full frame, NUM_PLANES=3 -> 1200+600+600 blocks. WS_frame_done exactly once, on block 2400. Block 2401 writes address 0.
- WS_start held high during WRITE -> no extra block. WS_bank=1 -> s_read_address in 64..95.
- Resetn pulse at WRITE cycle 10 -> we_n=1 immediately. Next start writes at address 0. WS_frame_restart after 5 blocks -> next block at address 0.

Source files
------------

// File: rtl/ws_block_writer.sv
// ws_block_writer
//   Streams one 8x8 pixel block from a DPRAM half into the frame buffer in
//   SRAM. Each DPRAM word holds two signed 16-bit pixels; each is clipped to
//   0..255 and the pair is written as one 16-bit SRAM word. The block's
//   position (column CB, row RB, plane Y/U/V) advances after every block so
//   that consecutive starts tile the whole frame in raster order per plane.
//
// Ports
//   CLOCK_50_I, Resetn     clock, asynchronous active-low reset
//   WS_start, WS_bank      start one block; bank selects the DPRAM half
//   WS_frame_restart       zero the block position (only acted on in IDLE)
//   WS_busy, WS_done       busy from accepted start through the done pulse
//   WS_frame_done          done pulse of the last block of the last plane
//   s_read_address/data    DPRAM read port (data one cycle after address)
//   s_write_enable         DPRAM write enable, never used (tied 0)
//   SRAM_address/write_data/we_n  registered SRAM write port
module ws_block_writer #(
  parameter int IMG_WIDTH   = 320,
  parameter int IMG_HEIGHT  = 240,
  parameter int CHROMA_HDIV = 2,
  parameter int CHROMA_VDIV = 1,
  parameter int NUM_PLANES  = 3,
  parameter int Y_BASE      = 0,
  parameter int U_BASE      = 38400,
  parameter int V_BASE      = 57600
) (
  input  logic        CLOCK_50_I,
  input  logic        Resetn,
  input  logic        WS_start,
  input  logic        WS_bank,
  input  logic        WS_frame_restart,
  output logic        WS_busy,
  output logic        WS_done,
  output logic        WS_frame_done,
  output logic [6:0]  s_read_address,
  input  logic [31:0] s_read_data,
  output logic        s_write_enable,
  output logic [17:0] SRAM_address,
  output logic [15:0] SRAM_write_data,
  output logic        SRAM_we_n
);

  // Blocks per row/column for each plane, and SRAM words per image row.
  localparam int Y_BW  = IMG_WIDTH / 8;
  localparam int Y_BH  = IMG_HEIGHT / 8;
  localparam int C_BW  = IMG_WIDTH / CHROMA_HDIV / 8;
  localparam int C_BH  = IMG_HEIGHT / CHROMA_VDIV / 8;
  localparam int Y_WPR = IMG_WIDTH / 2;
  localparam int C_WPR = IMG_WIDTH / (2 * CHROMA_HDIV);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_WRITE, S_DONE} state_t;

  state_t      state, state_nxt;
  logic [4:0]  word_cnt;
  logic        bank_q;
  logic [6:0]  rd_addr_q;
  logic [9:0]  cb, rb;
  logic [1:0]  plane;

  logic [9:0]  cb_max, rb_max;
  logic        cb_last, rb_last, plane_last;
  logic [4:0]  nxt_word;
  logic [17:0] row, col, base, y_off, c_off, addr_calc;

  function automatic logic [7:0] clip8(input logic [15:0] v);
    if (v[15])            return 8'h00;
    else if (v[14:8] != 0) return 8'hFF;
    else                  return v[7:0];
  endfunction

  // ---------------- FSM ----------------
  always_ff @(posedge CLOCK_50_I or negedge Resetn)
    if (!Resetn) state <= S_IDLE;
    else         state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (WS_start) state_nxt = S_FETCH;
      S_FETCH: state_nxt = S_WRITE;
      S_WRITE: if (word_cnt == 5'd31) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // ---------------- position / address ----------------
  always_comb begin
    cb_max     = (plane == 2'd0) ? 10'(Y_BW - 1) : 10'(C_BW - 1);
    rb_max     = (plane == 2'd0) ? 10'(Y_BH - 1) : 10'(C_BH - 1);
    cb_last    = (cb == cb_max);
    rb_last    = (rb == rb_max);
    plane_last = (plane == 2'(NUM_PLANES - 1));

    // The read address is registered, so during WRITE cycle k the bus shows
    // word k+1 and the word loaded now is k+2; after word 31 it parks at 0.
    if (word_cnt == 5'd31)      nxt_word = 5'd0;
    else if (word_cnt == 5'd30) nxt_word = 5'd31;
    else                        nxt_word = word_cnt + 5'd2;

    row   = 18'({rb, 3'b000}) + 18'(word_cnt[4:2]);
    col   = 18'({cb, 2'b00}) + 18'(word_cnt[1:0]);
    y_off = 18'(row * 18'(Y_WPR));
    c_off = 18'(row * 18'(C_WPR));
    case (plane)
      2'd0:    base = 18'(Y_BASE);
      2'd1:    base = 18'(U_BASE);
      default: base = 18'(V_BASE);
    endcase
    addr_calc = base + ((plane == 2'd0) ? y_off : c_off) + col;
  end

  // ---------------- datapath ----------------
  always_ff @(posedge CLOCK_50_I or negedge Resetn) begin
    if (!Resetn) begin
      word_cnt        <= '0;
      bank_q          <= 1'b0;
      rd_addr_q       <= '0;
      cb              <= '0;
      rb              <= '0;
      plane           <= '0;
      SRAM_we_n       <= 1'b1;
      SRAM_address    <= '0;
      SRAM_write_data <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          // Restart is applied before a coincident start is latched, so that
          // block lands at Y,0,0.
          if (WS_frame_restart) begin
            cb    <= '0;
            rb    <= '0;
            plane <= '0;
          end
          if (WS_start) begin
            bank_q    <= WS_bank;
            rd_addr_q <= {WS_bank, 1'b0, 5'd0};
            word_cnt  <= '0;
          end
        end
        S_FETCH: rd_addr_q <= {bank_q, 1'b0, 5'd1};
        S_WRITE: begin
          SRAM_address    <= addr_calc;
          SRAM_write_data <= {clip8(s_read_data[31:16]), clip8(s_read_data[15:0])};
          SRAM_we_n       <= 1'b0;
          word_cnt        <= word_cnt + 5'd1;
          rd_addr_q       <= {bank_q, 1'b0, nxt_word};
        end
        S_DONE: begin
          SRAM_we_n <= 1'b1;
          if (cb_last) begin
            cb <= '0;
            if (rb_last) begin
              rb    <= '0;
              plane <= plane_last ? 2'd0 : plane + 2'd1;
            end else begin
              rb <= rb + 10'd1;
            end
          end else begin
            cb <= cb + 10'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign WS_busy        = (state != S_IDLE);
  assign WS_done        = (state == S_DONE);
  assign WS_frame_done  = (state == S_DONE) && cb_last && rb_last && plane_last;
  assign s_read_address = rd_addr_q;
  assign s_write_enable = 1'b0;

endmodule

// File: tb/tb_ws_block_writer.sv
module tb_ws_block_writer;

  logic clk = 1'b0;
  logic rstn;
  always #10 clk = ~clk;

  // Instance 0: default geometry. Instance 1: tiny frame for full-frame wrap.
  logic        start0, bank0, rs0, busy0, done0, fd0, swe0, we0;
  logic [6:0]  ra0;
  logic [31:0] rd0;
  logic [17:0] sa0;
  logic [15:0] sd0;
  logic        start1, bank1, rs1, busy1, done1, fd1, swe1, we1;
  logic [6:0]  ra1;
  logic [31:0] rd1;
  logic [17:0] sa1;
  logic [15:0] sd1;

  ws_block_writer u_dut (
    .CLOCK_50_I(clk), .Resetn(rstn), .WS_start(start0), .WS_bank(bank0),
    .WS_frame_restart(rs0), .WS_busy(busy0), .WS_done(done0), .WS_frame_done(fd0),
    .s_read_address(ra0), .s_read_data(rd0), .s_write_enable(swe0),
    .SRAM_address(sa0), .SRAM_write_data(sd0), .SRAM_we_n(we0));

  ws_block_writer #(.IMG_WIDTH(32), .IMG_HEIGHT(16), .CHROMA_HDIV(2), .CHROMA_VDIV(2),
                    .NUM_PLANES(3), .Y_BASE(0), .U_BASE(1000), .V_BASE(2000)) u_small (
    .CLOCK_50_I(clk), .Resetn(rstn), .WS_start(start1), .WS_bank(bank1),
    .WS_frame_restart(rs1), .WS_busy(busy1), .WS_done(done1), .WS_frame_done(fd1),
    .s_read_address(ra1), .s_read_data(rd1), .s_write_enable(swe1),
    .SRAM_address(sa1), .SRAM_write_data(sd1), .SRAM_we_n(we1));

  // Shared DPRAM contents, one synchronous read port per instance.
  logic [31:0] dpram [128];
  always @(posedge clk) begin
    rd0 <= dpram[ra0];
    rd1 <= dpram[ra1];
  end

  int act = 0;
  logic        m_busy, m_done, m_fd, m_we, m_swe;
  logic [6:0]  m_ra;
  logic [17:0] m_sa;
  assign m_busy = act ? busy1 : busy0;
  assign m_done = act ? done1 : done0;
  assign m_fd   = act ? fd1   : fd0;
  assign m_we   = act ? we1   : we0;
  assign m_swe  = act ? swe1  : swe0;
  assign m_ra   = act ? ra1   : ra0;
  assign m_sa   = act ? sa1   : sa0;
  logic [15:0] m_sd;
  assign m_sd   = act ? sd1   : sd0;

  int checks = 0, failures = 0;
  int done_cnt = 0, fd_cnt = 0, we_low = 0;
  logic [33:0] exp_q [$];
  bit exp_bank = 0;
  int model_blk [2];

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, a, e);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int iw(input int s); return s ? 32 : 320; endfunction
  function automatic int ih(input int s); return s ? 16 : 240; endfunction
  function automatic int vd(input int s); return s ? 2 : 1; endfunction
  function automatic int ub(input int s); return s ? 1000 : 38400; endfunction
  function automatic int vb(input int s); return s ? 2000 : 57600; endfunction

  function automatic int plane_blocks(input int s, input int p);
    if (p == 0) return (iw(s) / 8) * (ih(s) / 8);
    return (iw(s) / 2 / 8) * (ih(s) / vd(s) / 8);
  endfunction

  function automatic int frame_total(input int s);
    return plane_blocks(s, 0) + 2 * plane_blocks(s, 1);
  endfunction

  function automatic void blk_pos(input int s, input int n, output int pl,
                                  output int rb, output int cb);
    int m, bw;
    m = n; pl = 0; rb = 0; cb = 0;
    for (int p = 0; p < 3; p++) begin
      bw = (p == 0) ? iw(s) / 8 : iw(s) / 2 / 8;
      if (m < plane_blocks(s, p)) begin
        pl = p; rb = m / bw; cb = m % bw;
        return;
      end
      m -= plane_blocks(s, p);
    end
  endfunction

  function automatic logic [17:0] exp_addr(input int s, input int pl, input int rb,
                                           input int cb, input int k);
    int wpr, base;
    wpr  = (pl == 0) ? iw(s) / 2 : iw(s) / 4;
    base = (pl == 0) ? 0 : (pl == 1) ? ub(s) : vb(s);
    return 18'(base + (rb * 8 + k / 4) * wpr + cb * 4 + k % 4);
  endfunction

  function automatic logic [7:0] clip(input logic [15:0] v);
    int sv;
    sv = int'($signed(v));
    if (sv < 0) return 8'd0;
    if (sv > 255) return 8'd255;
    return 8'(sv);
  endfunction

  function automatic logic [15:0] rnd_px();
    if ($urandom_range(0, 3) == 0) return 16'($urandom);
    return 16'($urandom_range(0, 255));
  endfunction

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (rstn) begin
      checks++;
      if (m_swe !== 1'b0) begin
        failures++;
        $display("FAIL s_write_enable got=%0b exp=0", m_swe);
      end
      if (m_we === 1'b0) begin
        logic [33:0] e;
        we_low++;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_write addr=%0d data=%0h", m_sa, m_sd);
        end else begin
          e = exp_q.pop_front();
          if ({m_sa, m_sd} !== e) begin
            failures++;
            $display("FAIL sram_write got addr=%0d data=%0h exp addr=%0d data=%0h",
                     m_sa, m_sd, e[33:16], e[15:0]);
          end
        end
      end
      if (m_done === 1'b1) done_cnt++;
      if (m_fd === 1'b1) fd_cnt++;
      if (m_busy === 1'b1) begin
        checks++;
        if (m_ra[6:5] !== {exp_bank, 1'b0}) begin
          failures++;
          $display("FAIL read_addr_bank got=%0d exp_bank=%0b", m_ra, exp_bank);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input bit st, input bit bk, input bit rs);
    if (act == 0) begin start0 = st; bank0 = bk; rs0 = rs; end
    else          begin start1 = st; bank1 = bk; rs1 = rs; end
  endtask

  // Loads a block into DPRAM, queues its expected SRAM writes and starts it.
  task automatic load_block(input bit bank, input int mode, input bit restart,
                            output bit efd);
    logic [31:0] w;
    int n, pl, rb, cb;
    for (int k = 0; k < 32; k++) begin
      if (mode == 1) w = {16'(2 * k), 16'(2 * k + 1)};
      else           w = {rnd_px(), rnd_px()};
      if (mode == 2 && k == 0) w = 32'hFFF6_012C;
      if (mode == 2 && k == 1) w = 32'h0080_8000;
      dpram[{bank, 1'b0, 5'(k)}] = w;
    end
    if (restart) model_blk[act] = 0;
    n = model_blk[act];
    blk_pos(act, n, pl, rb, cb);
    for (int k = 0; k < 32; k++) begin
      w = dpram[{bank, 1'b0, 5'(k)}];
      exp_q.push_back({exp_addr(act, pl, rb, cb, k), clip(w[31:16]), clip(w[15:0])});
    end
    efd = (n == frame_total(act) - 1);
    model_blk[act] = (n + 1) % frame_total(act);
    exp_bank = bank;
  endtask

  task automatic run_block(input bit bank, input int mode, input bit restart,
                           input bit hold, input longint exp_first);
    bit efd, gone;
    int d0, f0, w0;
    load_block(bank, mode, restart, efd);
    d0 = done_cnt; f0 = fd_cnt; w0 = we_low;
    @(posedge clk); #1 drive(1, bank, restart);
    @(posedge clk); #1 drive(hold, bank, 0);
    chk("busy_after_start", m_busy, 1);
    @(posedge clk); #1 chk("we_n_fetch", m_we, 1);
    @(posedge clk); #1 chk("we_n_first_low", m_we, 0);
    if (exp_first >= 0) chk("first_addr", m_sa, exp_first);
    gone = 0;
    for (int i = 0; i < 60 && !gone; i++) begin
      @(posedge clk); #1;
      if (i == 20) drive(0, bank, 0);
      if (!m_busy) gone = 1;
    end
    chk("block_finished", gone, 1);
    chk("done_pulses", done_cnt - d0, 1);
    chk("frame_done_pulses", fd_cnt - f0, efd);
    chk("we_low_cycles", we_low - w0, 32);
    chk("queue_drained", exp_q.size(), 0);
    exp_q.delete();
    if (hold) begin
      repeat (3) @(posedge clk);
      #1 chk("no_extra_block", m_busy, 0);
    end
  endtask

  task automatic abort_block(input bit bank);
    bit efd;
    load_block(bank, 0, 0, efd);
    @(posedge clk); #1 drive(1, bank, 0);
    @(posedge clk); #1 drive(0, bank, 0);
    @(posedge clk);
    @(posedge clk); #1 chk("abort_we_low", m_we, 0);
    repeat (9) @(posedge clk);
    #1 rstn = 1'b0;
    #1;
    chk("abort_we_n", we0, 1);
    chk("abort_busy", busy0, 0);
    chk("abort_addr", sa0, 0);
    chk("abort_data", sd0, 0);
    repeat (2) @(posedge clk);
    exp_q.delete();
    model_blk[0] = 0;
    model_blk[1] = 0;
    @(negedge clk) rstn = 1'b1;
  endtask

  initial begin
    int f0;
    rstn = 1'b0;
    start0 = 0; bank0 = 0; rs0 = 0;
    start1 = 0; bank1 = 0; rs1 = 0;
    model_blk[0] = 0; model_blk[1] = 0;
    for (int i = 0; i < 128; i++) dpram[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_we_n", we0, 1);
    chk("rst_addr", sa0, 0);
    chk("rst_data", sd0, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_done", done0, 0);
    chk("rst_frame_done", fd0, 0);
    chk("rst_read_addr", ra0, 0);
    chk("rst_small_we_n", we1, 1);
    @(negedge clk) rstn = 1'b1;

    act = 0;
    run_block(0, 1, 0, 0, 0);      // ramp data, first block at 0
    run_block(0, 2, 0, 0, -1);     // clipping words
    run_block(1, 0, 0, 1, -1);     // bank 1, start held through WRITE
    run_block(1, 0, 0, 0, -1);
    run_block(0, 0, 0, 0, -1);     // five blocks so far
    run_block(0, 0, 1, 0, 0);      // restart together with start
    run_block(1, 0, 0, 0, -1);
    run_block(0, 0, 0, 0, -1);
    @(posedge clk); #1 drive(0, 0, 1);   // lone restart pulse in IDLE
    @(posedge clk); #1 drive(0, 0, 0);
    model_blk[0] = 0;
    run_block(0, 0, 0, 0, 0);
    abort_block(1);
    for (int n = 0; n <= 1200; n++)
      run_block(1'($urandom_range(0, 1)), 0, 0, 0,
                (n == 0) ? 0 : (n == 39) ? 156 : (n == 40) ? 1280 :
                (n == 1200) ? 38400 : -1);

    act = 1;
    f0 = fd_cnt;
    for (int n = 0; n <= 12; n++)
      run_block(1'($urandom_range(0, 1)), 0, 0, 0,
                (n == 8) ? 1000 : (n == 10) ? 2000 : (n == 12) ? 0 : -1);
    chk("small_frame_done_total", fd_cnt - f0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
